mipi_tx_lane_distributor: RTL and testbench

Transmit-side counterpart of the CSI-2 receive lane path: accepts 32-bit packet words from the packet builder and distributes them byte-wise over four D-PHY HS lanes. Frames every burst with the HS sync byte (0xB8), a trail sequence and a minimum inter-burst gap, and drives the per-lane HS serializers. Sits between the CSI-2 packet/ECC/CRC generator and the Crosslink-NX D-PHY TX primitives; also used in loopback benches to stimulate the RX lane aligner.

---
 rtl/mipi_csi_pkg.sv | 21 ++
 rtl/mipi_tx_lane_delay.sv | 36 +++
 rtl/mipi_tx_lane_distributor.sv | 190 +++++++++++++++++++
 tb/tb_mipi_tx_lane_distributor.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mipi_csi_pkg.sv
// Shared CSI-2 TX definitions: sync byte, lane-distributor state encoding, default lane count.
// Pure declarations; no timing or backpressure of its own.
package mipi_csi_pkg;

  localparam logic [7:0] SYNC_BYTE     = 8'hB8;
  localparam int         LANES_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOT,
    ST_DATA,
    ST_TRAIL,
    ST_GAP
  } tx_state_e;

  function automatic logic [2:0] clamp_skew(input logic [2:0] skew, input int max_skew);
    if (int'(skew) > max_skew) return 3'(max_skew);
    return skew;
  endfunction

endpackage

// File: rtl/mipi_tx_lane_delay.sv
// Per-lane byte/valid delay line with a tap select; 0..MAX_SKEW cycles of delay.
// No backpressure: samples every cycle, sel=0 is a straight combinational pass.
module mipi_tx_lane_delay #(
  parameter int MAX_SKEW = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] lane_byte,
  input  logic       lane_valid,
  input  logic [2:0] sel,
  output logic [7:0] delayed_byte,
  output logic       delayed_valid
);

  logic [8:0] pipe [MAX_SKEW];
  logic [8:0] tap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_SKEW; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {lane_valid, lane_byte};
      for (int i = 1; i < MAX_SKEW; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_comb begin
    tap = {lane_valid, lane_byte};
    for (int i = 0; i < MAX_SKEW; i++) begin
      if (int'(sel) == i + 1) tap = pipe[i];
    end
  end

  assign {delayed_valid, delayed_byte} = tap;

endmodule

// File: rtl/mipi_tx_lane_distributor.sv
// Spreads 32-bit packet words over HS lanes with sync/trail/gap framing; one-cycle word-to-lane latency.
// ready_o depends on state only; optional per-lane skew injection under MIPI_TX_SKEW_INJECT_EN.
module mipi_tx_lane_distributor
  import mipi_csi_pkg::*;
#(
  parameter int LANES     = LANES_DEFAULT,
  parameter int TRAIL_LEN = 4,
  parameter int GAP_LEN   = 8
`ifdef MIPI_TX_SKEW_INJECT_EN
  ,
  parameter int MAX_SKEW  = 6
`endif
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [8*LANES-1:0]   word_i,
  input  logic                 word_valid_i,
  input  logic                 word_last_i,
  output logic                 ready_o,
  output logic [8*LANES-1:0]   byte_o,
  output logic [LANES-1:0]     bytes_valid_o,
  output logic                 hs_active_o,
  output logic                 underrun_o
`ifdef MIPI_TX_SKEW_INJECT_EN
  ,
  input  logic [3*LANES-1:0]   skew_i
`endif
);

  tx_state_e          state, state_next;
  logic [3:0]         cnt, cnt_next;
  logic [8*LANES-1:0] data, data_next;
  logic               last, last_next;
  logic               underrun, underrun_next;
  logic               accept;
  logic [8*LANES-1:0] raw_byte;
  logic [LANES-1:0]   raw_valid;

`ifdef MIPI_TX_SKEW_INJECT_EN
  logic               ext, ext_next;
  logic [3*LANES-1:0] skew_held, skew_next;
  logic [2:0]         ext_len;
`endif

  assign ready_o     = (state == ST_SOT) || ((state == ST_DATA) && !last);
  assign accept      = ready_o && word_valid_i;
  assign hs_active_o = (state == ST_SOT) || (state == ST_DATA) || (state == ST_TRAIL);
  assign underrun_o  = underrun;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      data      <= '0;
      last      <= 1'b0;
      underrun  <= 1'b0;
`ifdef MIPI_TX_SKEW_INJECT_EN
      ext       <= 1'b0;
      skew_held <= '0;
`endif
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      data      <= data_next;
      last      <= last_next;
      underrun  <= underrun_next;
`ifdef MIPI_TX_SKEW_INJECT_EN
      ext       <= ext_next;
      skew_held <= skew_next;
`endif
    end
  end

  // data holds the sync pattern through SOT so an underrun there trails off 0xB8.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    data_next     = data;
    last_next     = last;
    underrun_next = 1'b0;
`ifdef MIPI_TX_SKEW_INJECT_EN
    ext_next      = ext;
    skew_next     = skew_held;
`endif
    case (state)
      ST_IDLE: begin
        if (word_valid_i) begin
          state_next = ST_SOT;
          data_next  = {LANES{SYNC_BYTE}};
          last_next  = 1'b0;
`ifdef MIPI_TX_SKEW_INJECT_EN
          ext_next   = 1'b0;
          for (int k = 0; k < LANES; k++) begin
            skew_next[3*k +: 3] = clamp_skew(skew_i[3*k +: 3], MAX_SKEW);
          end
`endif
        end
      end
      ST_SOT, ST_DATA: begin
        if (last) begin
          state_next = ST_TRAIL;
          cnt_next   = 4'(TRAIL_LEN - 1);
        end else if (accept) begin
          state_next = ST_DATA;
          data_next  = word_i;
          last_next  = word_last_i;
        end else begin
          state_next    = ST_TRAIL;
          cnt_next      = 4'(TRAIL_LEN - 1);
          underrun_next = 1'b1;
        end
      end
      ST_TRAIL: begin
        if (cnt != 4'd0) begin
          cnt_next = cnt - 4'd1;
        end else begin
`ifdef MIPI_TX_SKEW_INJECT_EN
          // Hold HS active until the most-delayed lane has flushed its trail.
          if (!ext && (ext_len != 3'd0)) begin
            ext_next = 1'b1;
            cnt_next = {1'b0, ext_len} - 4'd1;
          end else begin
            ext_next   = 1'b0;
            state_next = ST_GAP;
            cnt_next   = 4'(GAP_LEN - 1);
          end
`else
          state_next = ST_GAP;
          cnt_next   = 4'(GAP_LEN - 1);
`endif
        end
      end
      ST_GAP: begin
        if (cnt != 4'd0) cnt_next = cnt - 4'd1;
        else             state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    raw_byte  = '0;
    raw_valid = '0;
    case (state)
      ST_SOT, ST_DATA: begin
        raw_byte  = data;
        raw_valid = '1;
      end
      ST_TRAIL: begin
        for (int k = 0; k < LANES; k++) begin
          raw_byte[8*k +: 8] = {8{~data[8*k+7]}};
        end
`ifdef MIPI_TX_SKEW_INJECT_EN
        if (ext) raw_byte = '0;
`endif
      end
      default: begin
        raw_byte  = '0;
        raw_valid = '0;
      end
    endcase
  end

`ifdef MIPI_TX_SKEW_INJECT_EN
  always_comb begin
    ext_len = 3'd0;
    for (int k = 0; k < LANES; k++) begin
      if (skew_held[3*k +: 3] > ext_len) ext_len = skew_held[3*k +: 3];
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane_delay
    mipi_tx_lane_delay #(
      .MAX_SKEW(MAX_SKEW)
    ) u_lane_delay (
      .clk          (clk_i),
      .rst_n        (reset_n_i),
      .lane_byte    (raw_byte[8*k +: 8]),
      .lane_valid   (raw_valid[k]),
      .sel          (skew_held[3*k +: 3]),
      .delayed_byte (byte_o[8*k +: 8]),
      .delayed_valid(bytes_valid_o[k])
    );
  end
`else
  assign byte_o        = raw_byte;
  assign bytes_valid_o = raw_valid;
`endif

endmodule

// File: tb/tb_mipi_tx_lane_distributor.sv
// Directed bench for mipi_tx_lane_distributor (default build, 4 lanes, trail 4, gap 8).
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_mipi_tx_lane_distributor;

  localparam logic [31:0] SYNC4 = 32'hB8B8B8B8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] word = '0;
  logic        word_valid = 1'b0;
  logic        word_last = 1'b0;
  logic        ready;
  logic [31:0] lane_bytes;
  logic [3:0]  bytes_valid;
  logic        hs_active;
  logic        underrun;
`ifdef MIPI_TX_SKEW_INJECT_EN
  logic [11:0] skew = '0;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mipi_tx_lane_distributor #(
    .LANES(4),
    .TRAIL_LEN(4),
    .GAP_LEN(8)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .word_i       (word),
    .word_valid_i (word_valid),
    .word_last_i  (word_last),
    .ready_o      (ready),
    .byte_o       (lane_bytes),
    .bytes_valid_o(bytes_valid),
    .hs_active_o  (hs_active),
    .underrun_o   (underrun)
`ifdef MIPI_TX_SKEW_INJECT_EN
    ,
    .skew_i       (skew)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic l, input logic [31:0] w);
    word_valid = v;
    word_last  = l;
    word       = w;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    #2;
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b exp 0", ready); end
    tests++; if (lane_bytes !== 32'h0) begin fails++; $display("FAIL reset_byte got %h exp 00000000", lane_bytes); end
    tests++; if (bytes_valid !== 4'h0) begin fails++; $display("FAIL reset_valid got %h exp 0", bytes_valid); end
    tests++; if (hs_active !== 1'b0) begin fails++; $display("FAIL reset_hs got %b exp 0", hs_active); end
    tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun got %b exp 0", underrun); end
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    tests++; if (ready !== 1'b0 || hs_active !== 1'b0) begin
      fails++; $display("FAIL idle_quiet got ready=%b hs=%b exp 0 0", ready, hs_active);
    end
  endtask

  // 3-word packet, valid throughout: SOT, 3 data beats, 4 trail, 8 gap, idle.
  task automatic test_basic();
    logic [31:0] e_byte;
    logic [3:0]  e_vld;
    logic        e_hs, e_rdy;
    for (int k = 1; k <= 17; k++) begin
      case (k)
        1, 2:    drive(1'b1, 1'b0, 32'h03020100);
        3:       drive(1'b1, 1'b0, 32'h07060504);
        4:       drive(1'b1, 1'b1, 32'h0B0A0908);
        default: drive(1'b0, 1'b0, 32'h0);
      endcase
      tick();
      e_byte = (k == 1) ? SYNC4 : (k == 2) ? 32'h03020100 : (k == 3) ? 32'h07060504 :
               (k == 4) ? 32'h0B0A0908 : (k <= 8) ? 32'hFFFFFFFF : 32'h0;
      e_vld  = (k <= 4) ? 4'hF : 4'h0;
      e_hs   = (k <= 8);
      e_rdy  = (k <= 3);
      tests++; if (lane_bytes !== e_byte) begin fails++; $display("FAIL basic_byte k=%0d got %h exp %h", k, lane_bytes, e_byte); end
      tests++; if (bytes_valid !== e_vld) begin fails++; $display("FAIL basic_valid k=%0d got %h exp %h", k, bytes_valid, e_vld); end
      tests++; if (hs_active !== e_hs) begin fails++; $display("FAIL basic_hs k=%0d got %b exp %b", k, hs_active, e_hs); end
      tests++; if (ready !== e_rdy) begin fails++; $display("FAIL basic_ready k=%0d got %b exp %b", k, ready, e_rdy); end
      tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL basic_underrun k=%0d got %b exp 0", k, underrun); end
    end
  endtask

  // Lanes 0..3 end on 7F,00,80,FF: trail FF,FF,00,00.
  task automatic test_trail_polarity();
    logic [31:0] e_byte;
    for (int k = 1; k <= 15; k++) begin
      if (k <= 2) drive(1'b1, 1'b1, 32'hFF80007F);
      else        drive(1'b0, 1'b0, 32'h0);
      tick();
      e_byte = (k == 1) ? SYNC4 : (k == 2) ? 32'hFF80007F : (k <= 6) ? 32'h0000FFFF : 32'h0;
      tests++; if (lane_bytes !== e_byte) begin fails++; $display("FAIL trail_byte k=%0d got %h exp %h", k, lane_bytes, e_byte); end
      tests++; if (hs_active !== (k <= 6)) begin fails++; $display("FAIL trail_hs k=%0d got %b exp %b", k, hs_active, (k <= 6)); end
      tests++; if (ready !== (k == 1)) begin fails++; $display("FAIL trail_ready k=%0d got %b exp %b", k, ready, (k == 1)); end
    end
  endtask

  // Valid drops after the second word: underrun pulse on the first trail cycle.
  task automatic test_underrun();
    logic [31:0] e_byte;
    for (int k = 1; k <= 16; k++) begin
      case (k)
        1, 2:    drive(1'b1, 1'b0, 32'h03020100);
        3:       drive(1'b1, 1'b0, 32'h87868584);
        default: drive(1'b0, 1'b0, 32'h0);
      endcase
      tick();
      e_byte = (k == 1) ? SYNC4 : (k == 2) ? 32'h03020100 : (k == 3) ? 32'h87868584 : 32'h0;
      tests++; if (lane_bytes !== e_byte) begin fails++; $display("FAIL under_byte k=%0d got %h exp %h", k, lane_bytes, e_byte); end
      tests++; if (bytes_valid !== ((k <= 3) ? 4'hF : 4'h0)) begin
        fails++; $display("FAIL under_valid k=%0d got %h exp %h", k, bytes_valid, ((k <= 3) ? 4'hF : 4'h0));
      end
      tests++; if (underrun !== (k == 4)) begin fails++; $display("FAIL under_pulse k=%0d got %b exp %b", k, underrun, (k == 4)); end
      tests++; if (hs_active !== (k <= 7)) begin fails++; $display("FAIL under_hs k=%0d got %b exp %b", k, hs_active, (k <= 7)); end
    end
  endtask

  // Second packet presented during GAP waits for IDLE->SOT.
  task automatic test_back_to_back();
    logic [31:0] e_byte;
    logic        e_hs, e_rdy;
    int          low_cnt;
    low_cnt = 0;
    for (int k = 1; k <= 31; k++) begin
      if (k <= 2)                  drive(1'b1, 1'b1, 32'h44332211);
      else if (k >= 8 && k <= 17)  drive(1'b1, 1'b1, 32'hA5A5A5A5);
      else                         drive(1'b0, 1'b0, 32'h0);
      tick();
      e_byte = (k == 1 || k == 16) ? SYNC4 : (k == 2) ? 32'h44332211 : (k == 17) ? 32'hA5A5A5A5 :
               (k >= 3 && k <= 6) ? 32'hFFFFFFFF : 32'h0;
      e_hs   = (k <= 6) || (k >= 16 && k <= 21);
      e_rdy  = (k == 1) || (k == 16);
      if (k >= 7 && k <= 15 && !hs_active) low_cnt++;
      tests++; if (lane_bytes !== e_byte) begin fails++; $display("FAIL b2b_byte k=%0d got %h exp %h", k, lane_bytes, e_byte); end
      tests++; if (hs_active !== e_hs) begin fails++; $display("FAIL b2b_hs k=%0d got %b exp %b", k, hs_active, e_hs); end
      tests++; if (ready !== e_rdy) begin fails++; $display("FAIL b2b_ready k=%0d got %b exp %b", k, ready, e_rdy); end
    end
    // 8 GAP cycles plus the IDLE cycle that samples the waiting word.
    tests++; if (low_cnt != 9) begin fails++; $display("FAIL b2b_gap_len got %0d exp 9", low_cnt); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 32'h03020100);
    tick();
    tick();
    tests++; if (lane_bytes !== 32'h03020100) begin fails++; $display("FAIL rmid_pre got %h exp 03020100", lane_bytes); end
    drive(1'b1, 1'b0, 32'h07060504);
    #2;
    reset_n = 1'b0;
    #1;
    tests++; if (lane_bytes !== 32'h0 || bytes_valid !== 4'h0) begin
      fails++; $display("FAIL rmid_byte got %h/%h exp 00000000/0", lane_bytes, bytes_valid);
    end
    tests++; if (hs_active !== 1'b0 || ready !== 1'b0 || underrun !== 1'b0) begin
      fails++; $display("FAIL rmid_ctrl got hs=%b rdy=%b un=%b exp 0 0 0", hs_active, ready, underrun);
    end
    tick();
    tests++; if (hs_active !== 1'b0 || ready !== 1'b0) begin
      fails++; $display("FAIL rmid_held got hs=%b rdy=%b exp 0 0", hs_active, ready);
    end
    reset_n = 1'b1;
    drive(1'b1, 1'b1, 32'h07060504);
    tick();
    tests++; if (lane_bytes !== SYNC4 || hs_active !== 1'b1) begin
      fails++; $display("FAIL rmid_sot got %h hs=%b exp b8b8b8b8 1", lane_bytes, hs_active);
    end
    tick();
    tests++; if (lane_bytes !== 32'h07060504 || ready !== 1'b0) begin
      fails++; $display("FAIL rmid_word got %h rdy=%b exp 07060504 0", lane_bytes, ready);
    end
    drive(1'b0, 1'b0, 32'h0);
    repeat (14) tick();
    tests++; if (hs_active !== 1'b0 || lane_bytes !== 32'h0) begin
      fails++; $display("FAIL rmid_drain got hs=%b byte=%h exp 0 00000000", hs_active, lane_bytes);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_trail_polarity();
    test_underrun();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
